// File: rtl/pga_pkg.sv
// Shared types and helpers for the PGA gain writer.
// Holds the FSM state encoding, the SPI frame width and the clamp/quantise
// function that turns a signed dB request into a PGA code and its actual gain.
package pga_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_CS_HOLD = 2'd2,
        ST_SETTLE  = 2'd3
    } pga_state_t;

    localparam int FRAME_W = 16;

    // code: PGA register value; qg: gain (dB, two's complement) that code produces
    typedef struct packed {
        logic [7:0] code;
        logic [7:0] qg;
    } gain_q_t;

    // Clamp to [min_db, max_db], then floor to the PGA step; all in 9-bit signed.
    function automatic gain_q_t quantise(input logic [7:0] gain_db,
                                         input int         min_db,
                                         input int         max_db,
                                         input int         step_log2);
        logic signed [8:0] g;
        logic signed [8:0] lo;
        logic signed [8:0] hi;
        logic signed [8:0] code;
        logic signed [8:0] qg;
        gain_q_t           res;
        g  = signed'({gain_db[7], gain_db});
        lo = 9'(min_db);
        hi = 9'(max_db);
        if (g < lo) g = lo;
        if (g > hi) g = hi;
        code     = (g - lo) >>> step_log2;
        qg       = lo + (code <<< step_log2);
        res.code = code[7:0];
        res.qg   = qg[7:0];
        return res;
    endfunction

endpackage

// File: rtl/pga_gain_writer_spi_tx_shifter.sv
// Write-only SPI mode-0 transmitter for one FRAME_W-bit frame, MSB first.
// i_load captures the frame and puts its MSB on MOSI in the same edge; SCLK
// rises CLK_DIV cycles later and toggles every CLK_DIV cycles for FRAME_W
// pulses. o_done is high during the last cycle before the final SCLK fall.
module spi_tx_shifter
    import pga_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic [FRAME_W-1:0] i_frame,
    output logic               o_sclk,
    output logic               o_mosi,
    output logic               o_done
);

    localparam int HALF_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W  = $clog2(FRAME_W);
    localparam logic [HALF_W-1:0] HALF_MAX = HALF_W'(CLK_DIV - 1);

    logic               r_active;
    logic               r_sclk;
    logic [HALF_W-1:0]  r_half;
    logic [BIT_W-1:0]   r_bits;
    logic [FRAME_W-1:0] r_shift;

    // Half-period and remaining-bit down-counters; shift on every SCLK fall
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_active <= 1'b0;
            r_sclk   <= 1'b0;
            r_half   <= '0;
            r_bits   <= '0;
            r_shift  <= '0;
        end else if (i_load) begin
            r_active <= 1'b1;
            r_sclk   <= 1'b0;
            r_half   <= HALF_MAX;
            r_bits   <= BIT_W'(FRAME_W - 1);
            r_shift  <= i_frame;
        end else if (r_active) begin
            if (r_half == '0) begin
                r_half <= HALF_MAX;
                if (!r_sclk) begin
                    r_sclk <= 1'b1;
                end else begin
                    r_sclk <= 1'b0;
                    if (r_bits == '0) begin
                        r_active <= 1'b0;
                        r_shift  <= '0;
                    end else begin
                        r_bits  <= r_bits - 1'b1;
                        r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
                    end
                end
            end else begin
                r_half <= r_half - 1'b1;
            end
        end
    end

    assign o_sclk = r_sclk;
    assign o_mosi = r_shift[FRAME_W-1];
    assign o_done = r_active && (r_half == '0) && r_sclk && (r_bits == '0);

endmodule

// File: rtl/pga_gain_writer.sv
// PGA gain writer: clamps/quantises a dB request, writes the PGA gain register
// over SPI and holds settled_o low until the analog front end has settled.
// Requests are latched into a single pending slot (latest wins); a request whose
// quantised gain equals the applied gain is dropped without a frame.
// Build option PGA_POWERUP_WRITE_EN: when defined, the default gain is written
// once right after reset release so the PGA and the applied-gain register agree.
module pga_gain_writer
    import pga_pkg::*;
#(
    parameter int         CLK_DIV         = 4,
    parameter int         SETTLE_CYCLES   = 1000,
    parameter int         GAIN_MIN_DB     = -6,
    parameter int         GAIN_MAX_DB     = 26,
    parameter int         STEP_LOG2       = 1,
    parameter logic [7:0] REG_ADDR        = 8'h02,
    parameter int         GAIN_DEFAULT_DB = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] gain_dB_i,
    input  logic       set_gain_i,
    output logic       spi_sclk_o,
    output logic       spi_mosi_o,
    output logic       spi_cs_n_o,
    output logic       busy_o,
    output logic [7:0] gain_applied_dB_o,
    output logic       settled_o
);

    localparam int CNT_W = (SETTLE_CYCLES > CLK_DIV) ? $clog2(SETTLE_CYCLES + 1)
                                                     : $clog2(CLK_DIV + 1);
    localparam gain_q_t DFLT_Q = quantise(8'(GAIN_DEFAULT_DB), GAIN_MIN_DB,
                                          GAIN_MAX_DB, STEP_LOG2);
`ifdef PGA_POWERUP_WRITE_EN
    localparam logic PWRUP = 1'b1;
`else
    localparam logic PWRUP = 1'b0;
`endif

    pga_state_t r_state;
    pga_state_t w_next;
    logic       r_pending;
    gain_q_t    r_pend_q;
    logic [7:0] r_wr_qg;
    logic [7:0] r_applied;
    logic       r_cs_n;
    logic [CNT_W-1:0] r_cnt;
    gain_q_t    w_req;
    logic       w_load;
    logic       w_clr_pend;
    logic       w_hold_end;
    logic       w_done;
    logic       w_force;

    assign w_req = quantise(gain_dB_i, GAIN_MIN_DB, GAIN_MAX_DB, STEP_LOG2);

`ifdef PGA_POWERUP_WRITE_EN
    logic r_force;

    // First write after reset goes out even though it matches the applied gain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        r_force <= 1'b1;
        else if (w_load) r_force <= 1'b0;
    end

    assign w_force = r_force;
`else
    assign w_force = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    // Next-state and control strobes
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_clr_pend = 1'b0;
        w_hold_end = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_pending) begin
                    w_clr_pend = 1'b1;
                    if ((r_pend_q.qg != r_applied) || w_force) begin
                        w_load = 1'b1;
                        w_next = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                if (w_done) w_next = ST_CS_HOLD;
            end
            ST_CS_HOLD: begin
                if (r_cnt == '0) begin
                    w_hold_end = 1'b1;
                    w_next     = (SETTLE_CYCLES == 0) ? ST_IDLE : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (r_cnt == '0) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Request latch: a new strobe always wins over the IDLE clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= PWRUP;
            r_pend_q  <= DFLT_Q;
        end else if (set_gain_i) begin
            r_pending <= 1'b1;
            r_pend_q  <= w_req;
        end else if (w_clr_pend) begin
            r_pending <= 1'b0;
        end
    end

    // CS hold and settle down-counter, reloaded on each phase entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if ((r_state == ST_SHIFT) && w_done) begin
            r_cnt <= CNT_W'(CLK_DIV - 1);
        end else if (w_hold_end) begin
            r_cnt <= CNT_W'(SETTLE_CYCLES - 1);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Chip select and applied gain; the written gain becomes visible as CS rises
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cs_n    <= 1'b1;
            r_wr_qg   <= 8'(GAIN_DEFAULT_DB);
            r_applied <= 8'(GAIN_DEFAULT_DB);
        end else if (w_load) begin
            r_cs_n  <= 1'b0;
            r_wr_qg <= r_pend_q.qg;
        end else if (w_hold_end) begin
            r_cs_n    <= 1'b1;
            r_applied <= r_wr_qg;
        end
    end

    spi_tx_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_frame ({REG_ADDR, r_pend_q.code}),
        .o_sclk  (spi_sclk_o),
        .o_mosi  (spi_mosi_o),
        .o_done  (w_done)
    );

    assign spi_cs_n_o        = r_cs_n;
    assign busy_o            = (r_state != ST_IDLE);
    assign gain_applied_dB_o = r_applied;
    assign settled_o         = (r_state == ST_IDLE) && !r_pending;

endmodule

// File: tb/tb_pga_gain_writer.sv
// Directed bench for pga_gain_writer with default parameters.
// A per-cycle SPI monitor reassembles frames; vectors come from a table, and
// the request-overwrite, no-change skip and mid-frame reset cases are sequenced by hand.
module tb_pga_gain_writer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] gain_dB_i = 8'd0;
    logic       set_gain_i = 1'b0;
    logic       spi_sclk_o;
    logic       spi_mosi_o;
    logic       spi_cs_n_o;
    logic       busy_o;
    logic [7:0] gain_applied_dB_o;
    logic       settled_o;

    pga_gain_writer dut (
        .clk               (clk),
        .rst               (rst),
        .gain_dB_i         (gain_dB_i),
        .set_gain_i        (set_gain_i),
        .spi_sclk_o        (spi_sclk_o),
        .spi_mosi_o        (spi_mosi_o),
        .spi_cs_n_o        (spi_cs_n_o),
        .busy_o            (busy_o),
        .gain_applied_dB_o (gain_applied_dB_o),
        .settled_o         (settled_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        prev_cs = 1'b1;
    logic        prev_sclk = 1'b0;
    logic [15:0] cap = '0;
    int          nbits = 0;
    int          cs_low_cnt = 0;
    int          cs_high_cnt = 0;
    logic        first_mosi = 1'b0;
    int          frames_done = 0;
    int          cs_falls = 0;
    logic [15:0] last_frame = '0;
    int          last_bits = 0;
    int          last_cslow = 0;
    int          last_gap = 0;
    int          last_applied = 0;

    typedef struct {
        logic [7:0]  gain;
        logic [15:0] frame;
        int          qg;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Advance one cycle and update the SPI monitor at the falling clk edge
    task automatic tick();
        @(negedge clk);
        if (!spi_cs_n_o) begin
            if (prev_cs) begin
                cs_falls++;
                last_gap   = cs_high_cnt;
                cap        = '0;
                nbits      = 0;
                cs_low_cnt = 0;
                first_mosi = spi_mosi_o;
            end
            cs_low_cnt++;
            if (spi_sclk_o && !prev_sclk) begin
                cap = {cap[14:0], spi_mosi_o};
                nbits++;
            end
        end else begin
            if (!prev_cs) begin
                frames_done++;
                last_frame   = cap;
                last_bits    = nbits;
                last_cslow   = cs_low_cnt;
                last_applied = int'($signed(gain_applied_dB_o));
                cs_high_cnt  = 1;
            end else begin
                cs_high_cnt++;
            end
        end
        prev_cs   = spi_cs_n_o;
        prev_sclk = spi_sclk_o;
    endtask

    task automatic req(input logic [7:0] g);
        gain_dB_i  = g;
        set_gain_i = 1'b1;
        tick();
        set_gain_i = 1'b0;
    endtask

    task automatic wait_frame(input string name);
        int start;
        int n;
        start = frames_done;
        n = 0;
        while ((frames_done == start) && (n < 3000)) begin
            tick();
            n++;
        end
        chk({name, "_frame_seen"}, frames_done - start, 1);
    endtask

    task automatic wait_settled(output int n);
        n = 0;
        while (!settled_o && (n < 3000)) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int falls0;
        int exp_settled_rst;

        vecs[0] = '{gain: 8'd10,         frame: 16'h0208, qg: 10};
        vecs[1] = '{gain: 8'(-20),       frame: 16'h0200, qg: -6};
        vecs[2] = '{gain: 8'd40,         frame: 16'h0210, qg: 26};
        vecs[3] = '{gain: 8'd7,          frame: 16'h0206, qg: 6};
        vecs[4] = '{gain: 8'(-3),        frame: 16'h0201, qg: -4};

`ifdef PGA_POWERUP_WRITE_EN
        exp_settled_rst = 0;
`else
        exp_settled_rst = 1;
`endif

        repeat (3) tick();
        chk("rst_cs_n", int'(spi_cs_n_o), 1);
        chk("rst_sclk", int'(spi_sclk_o), 0);
        chk("rst_mosi", int'(spi_mosi_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_applied", int'($signed(gain_applied_dB_o)), 0);
        chk("rst_settled", int'(settled_o), exp_settled_rst);
        rst = 1'b1;

`ifdef PGA_POWERUP_WRITE_EN
        tick();
        chk("pwrup_settled_low", int'(settled_o), 0);
        wait_frame("pwrup");
        chk("pwrup_frame", int'(last_frame), 16'h0203);
        chk("pwrup_settled_low2", int'(settled_o), 0);
        wait_settled(n);
        chk("pwrup_settle_cycles", n, 1000);
`else
        repeat (50) tick();
        chk("no_pwrup_frame", cs_falls, 0);
`endif

        for (int i = 0; i < 5; i++) begin
            req(vecs[i].gain);
            chk($sformatf("v%0d_settled_dip", i), int'(settled_o), 0);
            wait_frame($sformatf("v%0d", i));
            chk($sformatf("v%0d_frame", i), int'(last_frame), int'(vecs[i].frame));
            chk($sformatf("v%0d_bits", i), last_bits, 16);
            chk($sformatf("v%0d_cs_low", i), last_cslow, 132);
            chk($sformatf("v%0d_mosi_at_cs", i), int'(first_mosi), int'(vecs[i].frame[15]));
            chk($sformatf("v%0d_applied", i), last_applied, vecs[i].qg);
            chk($sformatf("v%0d_busy_settle", i), int'(busy_o), 1);
            wait_settled(n);
            chk($sformatf("v%0d_settle_cycles", i), n, 1000);
            chk($sformatf("v%0d_busy_idle", i), int'(busy_o), 0);
        end

        // Latest request wins: 4 is overwritten by 20 while 10 is being shifted
        req(8'd10);
        repeat (20) tick();
        req(8'd4);
        repeat (10) tick();
        req(8'd20);
        wait_frame("ow1");
        chk("ow1_frame", int'(last_frame), 16'h0208);
        chk("ow1_applied", last_applied, 10);
        wait_frame("ow2");
        chk("ow2_frame", int'(last_frame), 16'h020D);
        chk("ow2_gap", last_gap, 1001);
        chk("ow2_applied", last_applied, 20);
        wait_settled(n);
        chk("ow2_settle_cycles", n, 1000);
        falls0 = cs_falls;
        repeat (200) tick();
        chk("ow_no_extra_frame", cs_falls - falls0, 0);

        // 21 dB quantises to the applied 20 dB: one-cycle settled dip, no frame
        falls0 = cs_falls;
        req(8'd21);
        chk("skip_settled_dip", int'(settled_o), 0);
        tick();
        chk("skip_settled_back", int'(settled_o), 1);
        chk("skip_busy", int'(busy_o), 0);
        repeat (150) tick();
        chk("skip_no_cs", cs_falls - falls0, 0);
        chk("skip_applied", int'($signed(gain_applied_dB_o)), 20);

        // Asynchronous reset during the seventh SCLK pulse of a frame
        req(8'd0);
        n = 0;
        while (!(!spi_cs_n_o && (nbits == 7)) && (n < 500)) begin
            tick();
            n++;
        end
        chk("mid_reach_pulse7", nbits, 7);
        chk("mid_sclk_high", int'(spi_sclk_o), 1);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_cs_n", int'(spi_cs_n_o), 1);
        chk("mid_rst_sclk", int'(spi_sclk_o), 0);
        chk("mid_rst_applied", int'($signed(gain_applied_dB_o)), 0);
        chk("mid_rst_busy", int'(busy_o), 0);
        repeat (2) tick();
        rst = 1'b1;
        falls0 = cs_falls;
`ifdef PGA_POWERUP_WRITE_EN
        wait_frame("mid_pwrup");
        chk("mid_pwrup_frame", int'(last_frame), 16'h0203);
`else
        repeat (300) tick();
        chk("mid_no_retry", cs_falls - falls0, 0);
        chk("mid_settled", int'(settled_o), 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pga_gain_writer.md
Name: pga_gain_writer

Overview:
- Downstream consumer of the gain controller's `gain_dB_o` / `set_gain_o` request.
- Converts a requested signed dB gain into a PGA code by clamping and quantising it.
- Programs the external variable-gain amplifier over a write-only SPI link.
- Holds `settled_o` low until the analog front end has settled, so the upstream level tracker can discard transient samples.

Parameters:
- CLK_DIV, 4: clk cycles per SCLK half-period; must be ≥2.
- SETTLE_CYCLES, 1000: clk cycles to wait after CS deasserts before asserting settled_o.
- GAIN_MIN_DB, -6: lowest programmable gain, signed dB.
- GAIN_MAX_DB, 26: highest programmable gain, signed dB.
- STEP_LOG2, 1: PGA step is 2^STEP_LOG2 dB.
- REG_ADDR, 8'h02: PGA gain register address, sent as the frame header.
- GAIN_DEFAULT_DB, 0: gain assumed/applied at reset.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- gain_dB_i  in  8  signed requested gain in dB
- set_gain_i  in  1  one-cycle request strobe; samples gain_dB_i
- spi_sclk_o  out  1  SPI clock, mode 0 (idle low)
- spi_mosi_o  out  1  SPI data, MSB first
- spi_cs_n_o  out  1  chip select, active low
- busy_o  out  1  high whenever the FSM is not in IDLE
- gain_applied_dB_o  out  8  signed gain of the last completed write (after clamp/quantise)
- settled_o  out  1  high in IDLE when no request is pending

Behaviour:
- Reset values (rst low):
  - spi_sclk_o=0, spi_mosi_o=0, spi_cs_n_o=1, busy_o=0
  - gain_applied_dB_o=GAIN_DEFAULT_DB, settled_o=1
  - pending flag cleared, FSM in IDLE
- Clamp and quantise, all arithmetic signed 9-bit:
  - g = min(max(gain_dB_i, GAIN_MIN_DB), GAIN_MAX_DB)
  - code = (g − GAIN_MIN_DB) >> STEP_LOG2 (floor)
  - quantised gain qg = GAIN_MIN_DB + (code << STEP_LOG2)
- Frame: 16 bits = {REG_ADDR[7:0], code zero-extended to 8 bits}.
- Request latch:
  - set_gain_i in any state stores qg/code into a pending register and sets pending.
  - Latest request wins; earlier unserviced requests are overwritten.
- FSM states:
  - IDLE:
    - If pending and qg ≠ gain_applied_dB_o: clear pending, go to SHIFT next cycle.
    - If pending and qg == gain_applied_dB_o: clear pending, stay in IDLE; no frame is sent.
    - settled_o = !pending.
  - SHIFT:
    - CS low on entry; bit 15 is on MOSI at CS fall.
    - SCLK rises after CLK_DIV cycles and falls CLK_DIV later.
    - MOSI updates on each SCLK falling edge.
    - 16 SCLK pulses, SHIFT lasts exactly 32·CLK_DIV cycles; SCLK ends low.
  - CS_HOLD:
    - CLK_DIV cycles with CS still low, then CS deasserts.
    - gain_applied_dB_o updates to the written qg in the same cycle CS rises.
  - SETTLE:
    - SETTLE_CYCLES-cycle counter, then return to IDLE.
    - A new set_gain_i here only sets pending; the current settle runs to completion.
- settled_o:
  - Falls combinationally-registered on the cycle after set_gain_i, even while in IDLE.
  - Low throughout SHIFT, CS_HOLD and SETTLE.
- Simultaneous set_gain_i with the IDLE→SHIFT transition: the new request goes to pending; the write already started is unaffected.
- Reset mid-frame: CS deasserts and SCLK drops immediately (asynchronous); the partial frame is discarded and no retry is made.
- Counters saturate-free: SETTLE_CYCLES=0 skips SETTLE entirely.

Optional Feature:
- Macro: PGA_POWERUP_WRITE_EN.
- Defined: after reset release the FSM immediately writes the code for GAIN_DEFAULT_DB (SHIFT→CS_HOLD→SETTLE), with settled_o low until the write completes. This guarantees PGA/register agreement after a board-level reset.
- Undefined: no write until the first set_gain_i; the PGA's own power-on value is trusted to equal GAIN_DEFAULT_DB.

Decomposition:
- Package pga_pkg:
  - FSM state enum (IDLE, SHIFT, CS_HOLD, SETTLE)
  - FRAME_W=16
  - the clamp/quantise function
- Sub-module spi_tx_shifter:
  - Inputs: load, 16-bit frame; outputs: sclk, mosi, done.
  - Parameter CLK_DIV; owns the bit and half-period counters.
- The writer owns the request latch, compare-skip logic, CS sequencing and the settle counter.

Test Plan:
- Request gain_dB_i=10 with defaults → code 8, frame 16'h0208 on MOSI with 16 SCLK rising edges.
  - CS low for 128+4 cycles; gain_applied_dB_o=10 at CS rise; settled_o high 1000 cycles later.
- Request −20 → clamped to −6, frame 16'h0200. Request 40 → clamped to 26, frame 16'h0210. Request 7 → quantised to 6 (code 6).
- After 10 has been applied, request 11 → quantises to 10, so no CS activity; settled_o dips for one cycle only.
- During SHIFT of 10, strobe 4 and then 20 → exactly one further frame (code 13, 20 dB) follows after SETTLE; 4 dB is never written.
- Assert rst low at SCLK pulse 7 of a frame → CS=1, SCLK=0 asynchronously; gain_applied_dB_o=0; no frame after release (macro off).
- With PGA_POWERUP_WRITE_EN defined → a frame of 16'h0203 is emitted right after reset release, with settled_o low until settle completes.
